smi_register_responder: RTL and testbench

Downstream SMI target that terminates the request stream produced by the transaction arbiter and generates the matching response stream. Holds a small bank of 32-bit registers. It decodes single-word read and write request frames and returns response frames that echo the request tag, so that upstream response steering and transaction matching work unchanged. It serves as the simplest memory-mapped endpoint for arbiter bring-up and for control-register blocks.

---
 rtl/smi_register_responder.sv | 200 ++++++++++++++++++++
 tb/tb_smi_register_responder.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/smi_register_responder.sv
// rtl/smi_register_responder.sv - SMI target terminating single-word read/write frames against a 32-bit register bank
module smi_register_responder #(
    parameter int AddrWidth = 4
) (
    input  logic        clk,
    input  logic        srst_n,
    input  logic        smiReqInReady,
    input  logic [7:0]  smiReqInEofc,
    input  logic [31:0] smiReqInData,
    output logic        smiReqInStop,
    output logic        smiRespOutReady,
    output logic [7:0]  smiRespOutEofc,
    output logic [31:0] smiRespOutData,
    input  logic        smiRespOutStop,
    output logic        busy
);
    localparam int Depth = 1 << AddrWidth;
    localparam logic [7:0] OpWrite     = 8'h01;
    localparam logic [7:0] OpRead      = 8'h02;
    localparam logic [7:0] StOk        = 8'h00;
    localparam logic [7:0] StMalformed = 8'h80;
    localparam logic [7:0] StRange     = 8'h81;
    localparam logic [7:0] EofcFull    = 8'd4;

    typedef enum logic [2:0] {
        HDR,
        ADDR,
        WDATA,
        DRAIN,
        RESP_HDR,
        RESP_DATA
    } stateT;

    stateT state;
    stateT stateNext;

    logic [31:0]          bank [Depth];
    logic [7:0]           opcode;
    logic [7:0]           opcodeNext;
    logic [15:0]          tag;
    logic [15:0]          tagNext;
    logic [7:0]           status;
    logic [7:0]           statusNext;
    logic [AddrWidth-1:0] addr;
    logic [AddrWidth-1:0] addrNext;
    logic                 addrBad;
    logic                 addrBadNext;
    logic [31:0]          readData;
    logic [31:0]          readDataNext;
    logic                 commit;

    logic                 reqXfer;
    logic                 respXfer;
    logic                 inLast;
    logic                 inFull;
    logic                 inAddrBad;
    logic [AddrWidth-1:0] inAddr;

    // Stop is a registered output, so gating the transfer with it keeps the
    // request side from ever advancing while a response is outstanding.
    assign reqXfer   = smiReqInReady && !smiReqInStop;
    assign respXfer  = smiRespOutReady && !smiRespOutStop;
    assign inLast    = smiReqInEofc != 8'd0;
    assign inFull    = smiReqInEofc == EofcFull;
    assign inAddrBad = (smiReqInData >> AddrWidth) != 32'd0;
    assign inAddr    = smiReqInData[AddrWidth-1:0];

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            state <= HDR;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext    = state;
        opcodeNext   = opcode;
        tagNext      = tag;
        statusNext   = status;
        addrNext     = addr;
        addrBadNext  = addrBad;
        readDataNext = readData;
        commit       = 1'b0;
        case (state)
            HDR: begin
                if (reqXfer) begin
                    opcodeNext   = smiReqInData[7:0];
                    tagNext      = smiReqInData[31:16];
                    readDataNext = 32'd0;
                    if (inLast) begin
                        statusNext = StMalformed;
                        stateNext  = RESP_HDR;
                    end else begin
                        statusNext = StOk;
                        stateNext  = ADDR;
                    end
                end
            end
            ADDR: begin
                if (reqXfer) begin
                    addrNext    = inAddr;
                    addrBadNext = inAddrBad;
                    if (opcode == OpRead && inFull) begin
                        statusNext = inAddrBad ? StRange : StOk;
                        if (!inAddrBad) begin
                            readDataNext = bank[inAddr];
                        end
                        stateNext = RESP_HDR;
                    end else if (opcode == OpWrite && !inLast) begin
                        stateNext = WDATA;
                    end else begin
                        statusNext = StMalformed;
                        stateNext  = inLast ? RESP_HDR : DRAIN;
                    end
                end
            end
            WDATA: begin
                if (reqXfer) begin
                    if (inFull) begin
                        commit     = !addrBad;
                        statusNext = addrBad ? StRange : StOk;
                        stateNext  = RESP_HDR;
                    end else begin
                        // A short last flit already closes the frame; only an
                        // open frame needs draining.
                        statusNext = StMalformed;
                        stateNext  = inLast ? RESP_HDR : DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (reqXfer && inLast) begin
                    stateNext = RESP_HDR;
                end
            end
            RESP_HDR: begin
                if (respXfer) begin
                    stateNext = (opcode == OpRead) ? RESP_DATA : HDR;
                end
            end
            RESP_DATA: begin
                if (respXfer) begin
                    stateNext = HDR;
                end
            end
            default: stateNext = HDR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            for (int i = 0; i < Depth; i++) begin
                bank[i] <= 32'd0;
            end
        end else if (commit) begin
            bank[addr] <= smiReqInData;
        end
    end

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            opcode          <= 8'd0;
            tag             <= 16'd0;
            status          <= 8'd0;
            addr            <= '0;
            addrBad         <= 1'b0;
            readData        <= 32'd0;
            smiReqInStop    <= 1'b1;
            busy            <= 1'b0;
            smiRespOutReady <= 1'b0;
            smiRespOutEofc  <= 8'd0;
            smiRespOutData  <= 32'd0;
        end else begin
            opcode       <= opcodeNext;
            tag          <= tagNext;
            status       <= statusNext;
            addr         <= addrNext;
            addrBad      <= addrBadNext;
            readData     <= readDataNext;
            smiReqInStop <= (stateNext == RESP_HDR) || (stateNext == RESP_DATA);
            busy         <= stateNext != HDR;
            // Response flits are built from the next-state values so the
            // header is valid in the cycle right after the last request flit.
            if (stateNext == RESP_HDR && state != RESP_HDR) begin
                smiRespOutReady <= 1'b1;
                smiRespOutData  <= {tagNext, 8'h00, statusNext};
                smiRespOutEofc  <= (opcodeNext == OpRead) ? 8'd0 : EofcFull;
            end else if (state == RESP_HDR && stateNext == RESP_DATA) begin
                smiRespOutReady <= 1'b1;
                smiRespOutData  <= readData;
                smiRespOutEofc  <= EofcFull;
            end else if (respXfer) begin
                smiRespOutReady <= 1'b0;
                smiRespOutData  <= 32'd0;
                smiRespOutEofc  <= 8'd0;
            end
        end
    end
endmodule

// File: tb/tb_smi_register_responder.sv
// tb/tb_smi_register_responder.sv - randomized frame-level bench with a register-bank reference model
module tb_smi_register_responder;
    localparam int AW    = 4;
    localparam int Depth = 1 << AW;

    logic        clk = 1'b0;
    logic        srst_n;
    logic        reqReady;
    logic [7:0]  reqEofc;
    logic [31:0] reqData;
    logic        reqStop;
    logic        respReady;
    logic [7:0]  respEofc;
    logic [31:0] respData;
    logic        respStop;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int stopMode = 0;

    logic [31:0] mBank [Depth];
    logic [31:0] fd [$];
    logic [7:0]  fe [$];

    smi_register_responder #(.AddrWidth(AW)) dut (
        .clk(clk),
        .srst_n(srst_n),
        .smiReqInReady(reqReady),
        .smiReqInEofc(reqEofc),
        .smiReqInData(reqData),
        .smiReqInStop(reqStop),
        .smiRespOutReady(respReady),
        .smiRespOutEofc(respEofc),
        .smiRespOutData(respData),
        .smiRespOutStop(respStop),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", nm, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic [7:0] e);
        fd.push_back(d);
        fe.push_back(e);
    endtask

    task automatic sendFlit(input logic [31:0] d, input logic [7:0] e);
        int n;
        n = 0;
        if ($urandom % 4 == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        @(negedge clk);
        reqReady = 1'b1;
        reqData  = d;
        reqEofc  = e;
        while (reqStop && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("reqAccept", {31'd0, reqStop}, 32'd0);
        @(posedge clk);
        #1;
        reqReady = 1'b0;
        reqData  = $urandom;
        reqEofc  = 8'($urandom);
    endtask

    task automatic recvFlit(input logic [31:0] ed, input logic [7:0] ee, input bit strict);
        int n;
        bit held;
        bit done;
        logic [31:0] hd;
        logic [7:0]  he;
        n = 0;
        held = 0;
        done = 0;
        hd = 0;
        he = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            if (strict && n == 0) chk("respLatency", {31'd0, respReady}, 32'd1);
            if (respReady) begin
                if (held) begin
                    chk("holdData", respData, hd);
                    chk("holdEofc", {24'd0, respEofc}, {24'd0, he});
                end
                chk("reqStopInResp", {31'd0, reqStop}, 32'd1);
                chk("busyInResp", {31'd0, busy}, 32'd1);
                case (stopMode)
                    0:       respStop = 1'b0;
                    1:       respStop = 1'($urandom % 2);
                    default: respStop = ~respStop;
                endcase
                if (!respStop) begin
                    chk("respData", respData, ed);
                    chk("respEofc", {24'd0, respEofc}, {24'd0, ee});
                    @(posedge clk);
                    done = 1;
                end else begin
                    held = 1;
                    hd = respData;
                    he = respEofc;
                end
            end
            n++;
        end
        chk("respTransfer", {31'd0, done}, 32'd1);
    endtask

    // Expected response derived from the frame as a whole, not from parser states.
    task automatic doTxn(input int mode);
        logic [7:0]  op;
        logic [15:0] tg;
        logic [7:0]  st;
        logic [31:0] rd;
        logic [31:0] a;
        bit bad;
        bit isRd;
        int n;
        n    = fd.size();
        op   = fd[0][7:0];
        tg   = fd[0][31:16];
        isRd = (op == 8'h02);
        st   = 8'h80;
        rd   = 32'd0;
        a    = 32'd0;
        bad  = 0;
        if (n >= 2) begin
            a   = fd[1];
            bad = (a >> AW) != 0;
        end
        if (op == 8'h02 && n == 2 && fe[1] == 8'd4) begin
            st = bad ? 8'h81 : 8'h00;
            rd = bad ? 32'd0 : mBank[a[AW-1:0]];
        end else if (op == 8'h01 && n == 3 && fe[1] == 8'd0 && fe[2] == 8'd4) begin
            st = bad ? 8'h81 : 8'h00;
            if (!bad) mBank[a[AW-1:0]] = fd[2];
        end
        stopMode = mode;
        for (int i = 0; i < n; i++) sendFlit(fd[i], fe[i]);
        if (isRd) begin
            recvFlit({tg, 8'h00, st}, 8'd0, mode == 0);
            recvFlit(rd, 8'd4, mode == 0);
        end else begin
            recvFlit({tg, 8'h00, st}, 8'd4, mode == 0);
        end
        @(negedge clk);
        chk("busyIdle", {31'd0, busy}, 32'd0);
        chk("reqStopIdle", {31'd0, reqStop}, 32'd0);
        chk("respReadyIdle", {31'd0, respReady}, 32'd0);
        respStop = 1'b0;
        fd.delete();
        fe.delete();
    endtask

    task automatic readTxn(input logic [15:0] tg, input logic [31:0] a, input int mode);
        push({tg, 8'h00, 8'h02}, 8'd0);
        push(a, 8'd4);
        doTxn(mode);
    endtask

    task automatic writeTxn(input logic [15:0] tg, input logic [31:0] a, input logic [31:0] d, input int mode);
        push({tg, 8'h00, 8'h01}, 8'd0);
        push(a, 8'd0);
        push(d, 8'd4);
        doTxn(mode);
    endtask

    task automatic sweep();
        for (int i = 0; i < Depth; i++) readTxn(16'($urandom), 32'(i), int'($urandom % 3));
    endtask

    initial begin
        logic [15:0] tg;
        logic [31:0] a;
        int k;
        for (int i = 0; i < Depth; i++) mBank[i] = 32'd0;
        srst_n   = 1'b0;
        reqReady = 1'b0;
        reqEofc  = 8'd0;
        reqData  = 32'd0;
        respStop = 1'b0;
        repeat (3) @(negedge clk);
        chk("rstReqStop", {31'd0, reqStop}, 32'd1);
        chk("rstRespReady", {31'd0, respReady}, 32'd0);
        chk("rstRespEofc", {24'd0, respEofc}, 32'd0);
        chk("rstRespData", respData, 32'd0);
        chk("rstBusy", {31'd0, busy}, 32'd0);
        srst_n = 1'b1;
        @(negedge clk);
        chk("relReqStop", {31'd0, reqStop}, 32'd0);

        writeTxn(16'h0401, 32'd3, 32'hDEADBEEF, 0);
        readTxn(16'h0802, 32'd3, 0);

        readTxn(16'h1111, 32'd3, 2);
        readTxn(16'h2222, 32'd0, 2);

        push({16'h0C00, 8'h00, 8'h07}, 8'd0);
        push(32'd3, 8'd0);
        push(32'h12345678, 8'd0);
        push(32'h9ABCDEF0, 8'd4);
        doTxn(0);

        readTxn(16'h3333, 32'h10, 0);
        writeTxn(16'h4444, 32'h10, 32'hCAFEF00D, 1);

        push({16'h5555, 8'h00, 8'h01}, 8'd4);
        doTxn(0);
        push({16'h6666, 8'h00, 8'h02}, 8'd0);
        push(32'd3, 8'd2);
        doTxn(0);
        sweep();

        writeTxn(16'h7777, 32'd5, 32'h0BADCAFE, 0);
        push({16'h7778, 8'h00, 8'h01}, 8'd0);
        push(32'd5, 8'd0);
        for (int i = 0; i < 2; i++) sendFlit(fd[i], fe[i]);
        fd.delete();
        fe.delete();
        @(negedge clk);
        srst_n = 1'b0;
        @(negedge clk);
        chk("midRstReqStop", {31'd0, reqStop}, 32'd1);
        chk("midRstRespReady", {31'd0, respReady}, 32'd0);
        chk("midRstBusy", {31'd0, busy}, 32'd0);
        srst_n = 1'b1;
        for (int i = 0; i < Depth; i++) mBank[i] = 32'd0;
        @(negedge clk);
        chk("midRelReqStop", {31'd0, reqStop}, 32'd0);
        chk("midRelRespReady", {31'd0, respReady}, 32'd0);
        readTxn(16'h8888, 32'd5, 0);

        for (int t = 0; t < 80; t++) begin
            tg = 16'($urandom);
            if ($urandom % 4 == 0)
                a = (32'h1 << $urandom_range(AW, 31)) | 32'($urandom_range(0, Depth - 1));
            else
                a = 32'($urandom_range(0, Depth - 1));
            k = int'($urandom % 10);
            if (k < 4) begin
                push({tg, 8'h00, 8'h01}, 8'd0);
                push(a, 8'd0);
                push($urandom, 8'd4);
            end else if (k < 7) begin
                push({tg, 8'h00, 8'h02}, 8'd0);
                push(a, 8'd4);
            end else if (k == 7) begin
                push({tg, 8'h5A, 8'($urandom_range(3, 255))}, 8'd0);
                repeat ($urandom_range(0, 3)) push($urandom, 8'd0);
                push($urandom, 8'd4);
            end else if (k == 8) begin
                push({tg, 8'h00, 8'($urandom_range(1, 2))}, 8'($urandom_range(1, 4)));
            end else if ($urandom % 2 == 0) begin
                push({tg, 8'h00, 8'h02}, 8'd0);
                push(a, 8'($urandom_range(1, 3)));
            end else begin
                push({tg, 8'h00, 8'h01}, 8'd0);
                push(a, 8'd0);
                push($urandom, 8'd0);
                push($urandom, 8'd4);
            end
            doTxn(int'($urandom % 3));
        end
        sweep();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
